// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, element type and Q3.12 -> Q1.15 saturating conversion
// for the 2D DCT datapath.
package dct_pkg;
   localparam int DATA_W = 16;
   localparam int N = 8;
   localparam int Q115_FRAC = 15;
   localparam int Q312_FRAC = 12;
   localparam logic [DATA_W-1:0] Q115_MAX = 16'h7FFF;
   localparam logic [DATA_W-1:0] Q115_MIN = 16'h8000;
   typedef logic signed [DATA_W-1:0] elem_t;
   localparam elem_t Q312_ONE = elem_t'(1 << Q312_FRAC);
   // -1.0 itself shifts to exactly 0x8000, so only values strictly below it clip
   function automatic elem_t q312_to_q115(elem_t x);
      if (x >= Q312_ONE) return elem_t'(Q115_MAX);
      if (x < -Q312_ONE) return elem_t'(Q115_MIN);
      return x <<< (Q115_FRAC - Q312_FRAC);
   endfunction
endpackage

// File: rtl/dct_transpose_bank.sv
// dct_transpose_bank: one NxN element array, written a row at a time and read a
// column at a time through a combinational mux.
module dct_transpose_bank #(
   parameter int DATA_W = 16,
   parameter int N = 8
) (
   input  logic                clk,
   input  logic                we_i,
   input  logic [2:0]          row_i,
   input  logic [N*DATA_W-1:0] row_data_i,
   input  logic [2:0]          col_i,
   output logic [N*DATA_W-1:0] col_data_o
);
   import dct_pkg::*;
   logic [N*DATA_W-1:0] mem_q [N];
   always_ff @(posedge clk) begin
      if (we_i) mem_q[row_i] <= row_data_i;
   end
   always_comb begin
      col_data_o = '0;
      for (int r = 0; r < N; r++) col_data_o[r*DATA_W +: DATA_W] = mem_q[r][col_i*DATA_W +: DATA_W];
   end
endmodule

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong 8x8 transpose between row and column DCT passes.
// Define DCT_TRANSPOSE_Q115_SAT_EN to convert Q3.12 inputs to saturated Q1.15 on write.
module dct_transpose_buffer #(
   parameter int DATA_W = dct_pkg::DATA_W,
   parameter int N = dct_pkg::N
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*DATA_W-1:0] in_row,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*DATA_W-1:0] out_col,
   output logic [2:0]          out_col_idx,
   output logic                out_last
);
   import dct_pkg::*;
   if (N != 8) begin : g_bad_n
      $error("dct_transpose_buffer: N must be 8");
   end
   logic [1:0]          full_q, full_d;
   logic                wr_bank_q, rd_bank_q;
   logic [2:0]          wr_row_q, rd_col_q;
   logic                wr_fire, rd_fire;
   logic [N*DATA_W-1:0] wr_data;
   logic [N*DATA_W-1:0] bank_col [2];
   assign in_ready  = !full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = out_valid && out_ready;
`ifdef DCT_TRANSPOSE_Q115_SAT_EN
   for (genvar k = 0; k < N; k++) begin : g_conv
      assign wr_data[k*DATA_W +: DATA_W] = q312_to_q115(in_row[k*DATA_W +: DATA_W]);
   end
`else
   assign wr_data = in_row;
`endif
   for (genvar b = 0; b < 2; b++) begin : g_bank
      dct_transpose_bank #(.DATA_W(DATA_W), .N(N)) u_bank (
         .clk        (clk),
         .we_i       (wr_fire && wr_bank_q == 1'(b)),
         .row_i      (wr_row_q),
         .row_data_i (wr_data),
         .col_i      (rd_col_q),
         .col_data_o (bank_col[b])
      );
   end
   assign out_col     = out_valid ? bank_col[rd_bank_q] : '0;
   assign out_col_idx = rd_col_q;
   assign out_last    = out_valid && rd_col_q == 3'd7;
   // the writer only targets an empty bank and the reader a full one, so they never collide
   always_comb begin
      full_d = full_q;
      if (wr_fire && wr_row_q == 3'd7) full_d[wr_bank_q] = 1'b1;
      if (rd_fire && rd_col_q == 3'd7) full_d[rd_bank_q] = 1'b0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_row_q  <= '0;
         rd_col_q  <= '0;
      end else begin
         full_q <= full_d;
         if (wr_fire) begin
            wr_row_q <= wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) wr_bank_q <= !wr_bank_q;
         end
         if (rd_fire) begin
            rd_col_q <= rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) rd_bank_q <= !rd_bank_q;
         end
      end
   end
endmodule
